transmite_medida_bcd_uc: RTL and testbench

//  Control unit that sequences the BCD-to-ASCII serial transmit datapath to send a full

---
 rtl/transmite_medida_bcd_uc_pkg.sv | 39 +++
 rtl/transmite_medida_bcd_uc_contador_digitos.sv | 43 ++++
 rtl/transmite_medida_bcd_uc.sv | 156 +++++++++++++++
 tb/tb_transmite_medida_bcd_uc.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/transmite_medida_bcd_uc_pkg.sv
// transmite_medida_bcd_uc_pkg
// Shared constants for the BCD measurement transmit control unit.
// Holds the 4-bit state codes (also exposed on db_estado), the ASCII character
// that the datapath sends as a separator when SEPARADOR_TX_EN is defined, the
// legal N_BYTES range, and the digit-to-byte index helper.
package transmite_medida_bcd_uc_pkg;

    // State codes. The values are visible on db_estado, so they are fixed.
    localparam int unsigned ESTADO_W      = 4;
    localparam logic [3:0]  ST_INICIAL    = 4'h0;
    localparam logic [3:0]  ST_PREPARA    = 4'h1;
    localparam logic [3:0]  ST_TRANSMITE  = 4'h2;
    localparam logic [3:0]  ST_ESPERA     = 4'h3;
    localparam logic [3:0]  ST_PROXIMO    = 4'h4;
    localparam logic [3:0]  ST_SEPARADOR  = 4'h5;
    localparam logic [3:0]  ST_ESPERA_SEP = 4'h6;
    localparam logic [3:0]  ST_FINAL      = 4'hF;

    // Character the datapath emits for the separator frame ('#').
    localparam logic [7:0]  ASCII_SEPARADOR = 8'h23;

    // Supported measurement sizes, in packed-BCD bytes.
    localparam int unsigned N_BYTES_MIN = 1;
    localparam int unsigned N_BYTES_MAX = 8;

    // Single-cycle strobes decoded from the state register.
    typedef struct packed {
        logic inicio;   // start one digit frame in the datapath
        logic pronto;   // whole measurement has been sent
    } uc_strobes_t;

    // Digit k = 0 is the high nibble of the most significant byte, so each
    // pair of digits walks one byte further down.
    function automatic int unsigned byte_do_digito(input int unsigned n_bytes,
                                                   input int unsigned k);
        return n_bytes - 1 - (k >> 1);
    endfunction

endpackage

// File: rtl/transmite_medida_bcd_uc_contador_digitos.sv
// transmite_medida_bcd_uc_contador_digitos
// Digit counter for the measurement transmit control unit.
// Counts 0..N_DIGITOS-1 with a synchronous clear and a count enable; fim is
// high while the counter sits on the last digit. The asynchronous reset
// matches the control unit so an abort leaves the counter at 0 immediately.
module transmite_medida_bcd_uc_contador_digitos #(
    parameter int N_DIGITOS = 4,
    parameter int W_K       = 2
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           zera,
    input  logic           conta,
    output logic [W_K-1:0] valor,
    output logic           fim
);

    logic [W_K-1:0] cnt_q;
    logic [W_K-1:0] cnt_d;

    // Clear has priority over count; the caller never counts past the last digit.
    always_comb begin
        cnt_d = cnt_q;
        if (zera) begin
            cnt_d = '0;
        end else if (conta) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register, cleared at once by the asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign valor = cnt_q;
    assign fim   = (cnt_q == W_K'(N_DIGITOS - 1));

endmodule

// File: rtl/transmite_medida_bcd_uc.sv
// transmite_medida_bcd_uc
// Control unit that sends one multi-digit packed-BCD measurement through the
// BCD-to-ASCII serial datapath, most significant digit first, one ASCII digit
// per frame. For every digit it presents the byte/nibble selection, issues a
// one-cycle start strobe and waits for the datapath's one-cycle done pulse.
// Optional feature macro: SEPARADOR_TX_EN -- when defined, a separator frame
// ('#') is sent after the last digit and the envia_separador output exists.
module transmite_medida_bcd_uc
    import transmite_medida_bcd_uc_pkg::*;
#(
    parameter int N_BYTES = 2,
    parameter int W_SEL   = ($clog2(N_BYTES) > 0) ? $clog2(N_BYTES) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             partida,
    input  logic             pronto_transmissao_bcd,
    output logic [W_SEL-1:0] seletor_byte,
    output logic             seletor_valor,
    output logic             inicio_transmissao_bcd,
    output logic             ocupado,
    output logic             pronto,
`ifdef SEPARADOR_TX_EN
    output logic             envia_separador,
`endif
    output logic [3:0]       db_estado
);

    // One digit per nibble; counter width covers 0..2*N_BYTES-1.
    localparam int N_DIGITOS = 2 * N_BYTES;
    localparam int W_K       = $clog2(N_DIGITOS);

    logic [ESTADO_W-1:0] estado_q;
    logic [ESTADO_W-1:0] estado_d;
    logic [W_K-1:0]      k_q;
    logic                k_fim;
    logic                k_zera;
    logic                k_conta;
    uc_strobes_t         strobes;
`ifdef SEPARADOR_TX_EN
    logic                sep_ativo;
`endif

    // Digit counter. It is cleared in PREPARA and also in FINAL, so it already
    // reads 0 when the next measurement enters PREPARA and the selection for
    // the first digit is valid from that cycle on.
    assign k_zera  = (estado_q == ST_PREPARA) || (estado_q == ST_FINAL);
    assign k_conta = (estado_q == ST_PROXIMO) && !k_fim;

    transmite_medida_bcd_uc_contador_digitos #(
        .N_DIGITOS (N_DIGITOS),
        .W_K       (W_K)
    ) u_contador_digitos (
        .clock (clock),
        .reset (reset),
        .zera  (k_zera),
        .conta (k_conta),
        .valor (k_q),
        .fim   (k_fim)
    );

    // State register; reset aborts any transfer in progress without a pronto.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= ST_INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next-state logic. partida is only looked at in INICIAL and the datapath
    // done pulse only in the waiting states, so stray pulses are harmless.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            ST_INICIAL: begin
                if (partida) begin
                    estado_d = ST_PREPARA;
                end
            end
            ST_PREPARA: begin
                estado_d = ST_TRANSMITE;
            end
            ST_TRANSMITE: begin
                estado_d = ST_ESPERA;
            end
            ST_ESPERA: begin
                if (pronto_transmissao_bcd) begin
                    estado_d = ST_PROXIMO;
                end
            end
            ST_PROXIMO: begin
                if (k_fim) begin
`ifdef SEPARADOR_TX_EN
                    estado_d = ST_SEPARADOR;
`else
                    estado_d = ST_FINAL;
`endif
                end else begin
                    estado_d = ST_TRANSMITE;
                end
            end
`ifdef SEPARADOR_TX_EN
            ST_SEPARADOR: begin
                estado_d = ST_ESPERA_SEP;
            end
            ST_ESPERA_SEP: begin
                if (pronto_transmissao_bcd) begin
                    estado_d = ST_FINAL;
                end
            end
`endif
            ST_FINAL: begin
                estado_d = ST_INICIAL;
            end
            default: begin
                estado_d = ST_INICIAL;
            end
        endcase
    end

    // Moore strobe decode: the datapath start and the measurement-done pulse.
    always_comb begin
        strobes = '0;
        case (estado_q)
            ST_TRANSMITE: strobes.inicio = 1'b1;
`ifdef SEPARADOR_TX_EN
            ST_SEPARADOR: strobes.inicio = 1'b1;
`endif
            ST_FINAL:     strobes.pronto = 1'b1;
            default:      strobes = '0;
        endcase
    end

`ifdef SEPARADOR_TX_EN
    // Separator flag held for the whole separator frame, strobe included.
    always_comb begin
        sep_ativo = (estado_q == ST_SEPARADOR) || (estado_q == ST_ESPERA_SEP);
    end

    assign envia_separador = sep_ativo;
`endif

    // Every state other than INICIAL belongs to a measurement in progress.
    assign ocupado = (estado_q != ST_INICIAL);

    // Byte/nibble selection only follows the counter while busy, so an idle
    // or freshly reset unit presents all zeros to the datapath.
    assign seletor_byte  = ocupado ? W_SEL'(byte_do_digito(N_BYTES, 32'(k_q))) : '0;
    assign seletor_valor = ocupado & ~k_q[0];

    assign inicio_transmissao_bcd = strobes.inicio;
    assign pronto                 = strobes.pronto;
    assign db_estado              = estado_q;

endmodule

// File: tb/tb_transmite_medida_bcd_uc.sv
// tb_transmite_medida_bcd_uc
// Self-checking bench for transmite_medida_bcd_uc with N_BYTES = 2, 1 and 8.
// A cycle table walks one measurement on the N_BYTES=2 unit; randomized
// measurements are then checked against a digit-order model built from the
// (byte, nibble) rule and the done->strobe latency. Honours SEPARADOR_TX_EN.
module tb_transmite_medida_bcd_uc;

    logic clock = 1'b0;
    logic reset;
    logic [2:0]      partida;
    logic [2:0]      prtx;
    logic [2:0]      inicio;
    logic [2:0]      ocup;
    logic [2:0]      pronto;
    logic [2:0]      sep;
    logic [2:0]      sv;
    logic [2:0][3:0] db;
    logic [2:0][2:0] sb;
    logic            sb_a;
    logic            sb_b;
    logic [2:0]      sb_c;

    int errors = 0;
    int checks = 0;

`ifdef SEPARADOR_TX_EN
    localparam int SEP_EXTRA = 1;
`else
    localparam int SEP_EXTRA = 0;
    assign sep = 3'b000;
`endif

    always #5 clock = ~clock;

    transmite_medida_bcd_uc #(.N_BYTES(2)) u_n2 (
        .clock(clock), .reset(reset), .partida(partida[0]),
        .pronto_transmissao_bcd(prtx[0]), .seletor_byte(sb_a),
        .seletor_valor(sv[0]), .inicio_transmissao_bcd(inicio[0]),
        .ocupado(ocup[0]), .pronto(pronto[0]),
`ifdef SEPARADOR_TX_EN
        .envia_separador(sep[0]),
`endif
        .db_estado(db[0]));

    transmite_medida_bcd_uc #(.N_BYTES(1)) u_n1 (
        .clock(clock), .reset(reset), .partida(partida[1]),
        .pronto_transmissao_bcd(prtx[1]), .seletor_byte(sb_b),
        .seletor_valor(sv[1]), .inicio_transmissao_bcd(inicio[1]),
        .ocupado(ocup[1]), .pronto(pronto[1]),
`ifdef SEPARADOR_TX_EN
        .envia_separador(sep[1]),
`endif
        .db_estado(db[1]));

    transmite_medida_bcd_uc #(.N_BYTES(8)) u_n8 (
        .clock(clock), .reset(reset), .partida(partida[2]),
        .pronto_transmissao_bcd(prtx[2]), .seletor_byte(sb_c),
        .seletor_valor(sv[2]), .inicio_transmissao_bcd(inicio[2]),
        .ocupado(ocup[2]), .pronto(pronto[2]),
`ifdef SEPARADOR_TX_EN
        .envia_separador(sep[2]),
`endif
        .db_estado(db[2]));

    assign sb[0] = {2'b00, sb_a};
    assign sb[1] = {2'b00, sb_b};
    assign sb[2] = sb_c;

    typedef struct {
        logic       partida;
        logic       prtx;
        logic [3:0] db;
        logic       inicio;
        logic       ocup;
        logic       pronto;
        logic [2:0] sb;
        logic       sv;
        logic       sep;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic p, input logic d, input logic [3:0] e,
                                input logic i, input logic o, input logic pr,
                                input int b, input logic v, input logic s);
        vec_t r;
        r.partida = p; r.prtx = d; r.db = e; r.inicio = i; r.ocup = o;
        r.pronto = pr; r.sb = 3'(b); r.sv = v; r.sep = s;
        tbl.push_back(r);
    endfunction

    function automatic logic [11:0] outs(input int i);
        return {db[i], inicio[i], ocup[i], pronto[i], sb[i], sv[i], sep[i]};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One measurement on instance inst (nb bytes). Done pulses are returned
    // dmin..dmax cycles after each strobe. poke raises partida while the
    // second digit is in flight; abort_at > 0 resets during that digit's wait;
    // stray injects done pulses while no digit is outstanding.
    task automatic run_meas(input int inst, input int nb, input int dmin, input int dmax,
                            input bit poke, input int abort_at, input bit stray);
        int exp_n;
        int got_n;
        int cyc;
        int due;
        int last_done;
        int strobe_cyc;
        int prontos;
        bit done_flag;
        bit aborted;
        int rec_b[$];
        int rec_v[$];
        int rec_s[$];
        exp_n = 2 * nb + SEP_EXTRA;
        got_n = 0; cyc = 0; due = -1; last_done = -1; strobe_cyc = -1;
        prontos = 0; done_flag = 0; aborted = 0;
        partida[inst] = 1'b1;
        while (!done_flag && cyc < 3000) begin
            @(negedge clock);
            cyc++;
            partida[inst] = 1'b0;
            prtx[inst] = 1'b0;
            if (pronto[inst]) begin
                prontos++;
                check("strobes_before_pronto", got_n, exp_n);
                check("no_done_pending_at_pronto", due, -1);
                done_flag = 1;
            end else begin
                if (inicio[inst]) begin
                    if (got_n == 0) check("partida_to_first_strobe", cyc, 2);
                    else            check("done_to_next_strobe", cyc - last_done, 2);
                    rec_b.push_back(int'(sb[inst]));
                    rec_v.push_back(int'(sv[inst]));
                    rec_s.push_back(int'(sep[inst]));
                    got_n++;
                    strobe_cyc = cyc;
                    due = cyc + int'($urandom_range(dmax, dmin));
                end
                if (abort_at > 0 && got_n == abort_at && cyc == strobe_cyc + 2) begin
                    check("abort_in_espera", int'(db[inst]), 3);
                    #2 reset = 1'b1;
                    #1;
                    check("abort_outputs_cleared", int'(outs(inst)), 0);
                    check("abort_no_pronto", prontos, 0);
                    @(negedge clock);
                    reset = 1'b0;
                    aborted = 1;
                    done_flag = 1;
                end else begin
                    if (poke && got_n == 2 && cyc == strobe_cyc + 1) partida[inst] = 1'b1;
                    if (due == cyc) begin
                        prtx[inst] = 1'b1;
                        due = -1;
                        last_done = cyc;
                    end else if (stray && due == -1 && db[inst] != 4'h3 && db[inst] != 4'h6
                                 && $urandom_range(3, 0) == 0) begin
                        prtx[inst] = 1'b1;
                    end
                end
            end
        end
        partida[inst] = 1'b0;
        prtx[inst] = 1'b0;
        if (!done_flag) check("measurement_timeout", cyc, 0);
        for (int k = 0; k < got_n && k < exp_n; k++) begin
            if (k < 2 * nb) begin
                check($sformatf("n%0d_digit%0d_byte", nb, k), rec_b[k], nb - 1 - k / 2);
                check($sformatf("n%0d_digit%0d_nibble", nb, k), rec_v[k], (k % 2 == 0) ? 1 : 0);
                check($sformatf("n%0d_digit%0d_sep", nb, k), rec_s[k], 0);
            end else begin
                check($sformatf("n%0d_separator_flag", nb), rec_s[k], 1);
            end
        end
        if (!aborted) begin
            check($sformatf("n%0d_strobe_count", nb), got_n, exp_n);
            check($sformatf("n%0d_pronto_count", nb), prontos, 1);
            @(negedge clock);
            check($sformatf("n%0d_idle_after_pronto", nb), int'(outs(inst)), 0);
        end
        $display("meas inst=%0d nbytes=%0d strobes=%0d prontos=%0d aborted=%0d cycles=%0d",
                 inst, nb, got_n, prontos, aborted, cyc);
    endtask

    initial begin
        partida = '0;
        prtx = '0;
        reset = 1'b1;
        #12;
        for (int i = 0; i < 3; i++) check($sformatf("reset_state_%0d", i), int'(outs(i)), 0);
        @(negedge clock);
        reset = 1'b0;

        // p, done, db, inicio, ocup, pronto, byte, nibble, sep
        add(0, 1, 4'h0, 0, 0, 0, 0, 0, 0);   // stray done in INICIAL
        add(1, 0, 4'h1, 0, 1, 0, 1, 1, 0);
        add(0, 0, 4'h2, 1, 1, 0, 1, 1, 0);
        add(0, 0, 4'h3, 0, 1, 0, 1, 1, 0);
        add(0, 0, 4'h3, 0, 1, 0, 1, 1, 0);
        add(0, 1, 4'h4, 0, 1, 0, 1, 1, 0);
        add(0, 0, 4'h2, 1, 1, 0, 1, 0, 0);
        add(0, 1, 4'h3, 0, 1, 0, 1, 0, 0);   // stray done in TRANSMITE
        add(0, 1, 4'h4, 0, 1, 0, 1, 0, 0);
        add(0, 0, 4'h2, 1, 1, 0, 0, 1, 0);
        add(1, 0, 4'h3, 0, 1, 0, 0, 1, 0);   // partida while busy
        add(1, 0, 4'h3, 0, 1, 0, 0, 1, 0);
        add(0, 1, 4'h4, 0, 1, 0, 0, 1, 0);
        add(0, 0, 4'h2, 1, 1, 0, 0, 0, 0);
        add(0, 0, 4'h3, 0, 1, 0, 0, 0, 0);
        add(0, 1, 4'h4, 0, 1, 0, 0, 0, 0);
`ifdef SEPARADOR_TX_EN
        add(0, 0, 4'h5, 1, 1, 0, 0, 0, 1);
        add(0, 0, 4'h6, 0, 1, 0, 0, 0, 1);
        add(0, 1, 4'hF, 0, 1, 1, 0, 0, 0);
`else
        add(0, 0, 4'hF, 0, 1, 1, 0, 0, 0);
`endif
        add(0, 1, 4'h0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 4'h0, 0, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            partida[0] = tbl[i].partida;
            prtx[0] = tbl[i].prtx;
            @(negedge clock);
            check($sformatf("table_row_%0d", i), int'(outs(0)),
                  int'({tbl[i].db, tbl[i].inicio, tbl[i].ocup, tbl[i].pronto,
                        tbl[i].sb, tbl[i].sv, tbl[i].sep}));
            $display("row %0d partida=%0b done=%0b state=%0h", i, tbl[i].partida,
                     tbl[i].prtx, db[0]);
        end
        partida[0] = 1'b0;
        prtx[0] = 1'b0;

        run_meas(0, 2, 10, 10, 0, 0, 0);
        run_meas(0, 2, 10, 10, 1, 0, 0);
        run_meas(0, 2, 3, 6, 0, 3, 0);
        run_meas(0, 2, 2, 5, 0, 0, 0);
        run_meas(1, 1, 1, 4, 0, 0, 1);
        run_meas(2, 8, 1, 4, 0, 0, 1);
        repeat (8) begin
            int inst;
            int nb;
            inst = int'($urandom_range(2, 0));
            nb = (inst == 0) ? 2 : ((inst == 1) ? 1 : 8);
            run_meas(inst, nb, 1, int'($urandom_range(9, 1)), 1'($urandom_range(1, 0)), 0, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
